// File: rtl/level_pkg.sv
// Shared encodings for the level writer: command ops, response status,
// write-select bit positions and the FSM state type.
package level_pkg;

   typedef enum logic [1:0] {
      OP_INSERT = 2'd0,
      OP_LINK   = 2'd1,
      OP_CLEAR  = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      RSP_OK       = 3'd0,
      RSP_FULL     = 3'd1,
      RSP_OCCUPIED = 3'd2,
      RSP_DUP      = 3'd3,
      RSP_BADADDR  = 3'd4,
      RSP_BADOP    = 3'd5
   } status_e;

   localparam int SEL_WORD  = 0;
   localparam int SEL_LEFT  = 1;
   localparam int SEL_RIGHT = 2;
   localparam logic [2:0] SEL_ALL = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CMP  = 3'd2,
      S_WR   = 3'd3,
      S_CLR  = 3'd4,
      S_RESP = 3'd5
   } state_e;

endpackage

// File: rtl/level_writer.sv
// Write-side engine for one lookup level: allocates nodes, links child
// pointers into parents by key comparison, and bulk-clears the level.
module level_writer
   import level_pkg::*;
#(
   parameter int WORD_SIZE    = 16,
   parameter int POINTER_SIZE = 16,
   parameter int MEM_SIZE     = 2,
   parameter int LEVEL_ID     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [WORD_SIZE-1:0]    cmd_key,
   input  logic [POINTER_SIZE-1:0] cmd_parent_addr,
   input  logic [POINTER_SIZE-1:0] cmd_child_ptr,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [2:0]              rsp_status,
   output logic [POINTER_SIZE-1:0] rsp_addr,
   output logic [POINTER_SIZE:0]   alloc_count,
   output logic                    mem_rd_en,
   output logic [POINTER_SIZE-1:0] mem_rd_addr,
   input  logic [WORD_SIZE-1:0]    mem_rd_word,
   input  logic                    mem_rd_lp_valid,
   input  logic                    mem_rd_rp_valid,
   output logic                    mem_wr_en,
   output logic [POINTER_SIZE-1:0] mem_wr_addr,
   output logic [2:0]              mem_wr_sel,
   output logic [WORD_SIZE-1:0]    mem_wr_word,
   output logic [POINTER_SIZE-1:0] mem_wr_ptr,
   output logic                    mem_wr_ptr_valid
);

   localparam int AW = POINTER_SIZE;
   localparam int CW = POINTER_SIZE + 1;
   localparam logic [CW-1:0] MemSizeC = CW'(MEM_SIZE);
   localparam logic [AW-1:0] LastAddr = AW'(MEM_SIZE - 1);

   if (MEM_SIZE < 1 || LEVEL_ID < 0 ||
       (POINTER_SIZE < 31 && MEM_SIZE > (1 << POINTER_SIZE))) begin : g_bad_param
      $error("level_writer: MEM_SIZE must be 1..2**POINTER_SIZE and LEVEL_ID >= 0");
   end

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [WORD_SIZE-1:0] key_q, key_d;
   logic [AW-1:0]        parent_q, parent_d;
   logic [AW-1:0]        child_q, child_d;
   status_e              status_q, status_d;
   logic [AW-1:0]        raddr_q, raddr_d;
   logic [CW-1:0]        alloc_q, alloc_d;

   logic                 cmd_ready_q, cmd_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [2:0]           rsp_status_q, rsp_status_d;
   logic [AW-1:0]        rsp_addr_q, rsp_addr_d;
   logic                 rd_en_q, rd_en_d;
   logic [AW-1:0]        rd_addr_q, rd_addr_d;
   logic                 wr_en_q, wr_en_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic [2:0]           wr_sel_q, wr_sel_d;
   logic [WORD_SIZE-1:0] wr_word_q, wr_word_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic                 wr_ptr_valid_q, wr_ptr_valid_d;

   // Output registers are loaded with the values for the state being entered,
   // so every strobe lines up with the cycle its state occupies.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      key_d          = key_q;
      parent_d       = parent_q;
      child_d        = child_q;
      status_d       = status_q;
      raddr_d        = raddr_q;
      alloc_d        = alloc_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_status_d   = rsp_status_q;
      rsp_addr_d     = rsp_addr_q;
      rd_en_d        = 1'b0;
      rd_addr_d      = rd_addr_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_sel_d       = '0;
      wr_word_d      = '0;
      wr_ptr_d       = '0;
      wr_ptr_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d     = op_e'(cmd_op);
               key_d    = cmd_key;
               parent_d = cmd_parent_addr;
               child_d  = cmd_child_ptr;
               raddr_d  = '0;
               case (op_e'(cmd_op))
                  OP_INSERT: begin
                     state_d = S_WR;
                     if (alloc_q == MemSizeC) begin
                        status_d = RSP_FULL;
                     end else begin
                        status_d  = RSP_OK;
                        raddr_d   = alloc_q[AW-1:0];
                        wr_en_d   = 1'b1;
                        wr_addr_d = alloc_q[AW-1:0];
                        wr_sel_d  = SEL_ALL;
                        wr_word_d = cmd_key;
                     end
                  end
                  OP_LINK: begin
                     raddr_d = cmd_parent_addr;
                     if ({1'b0, cmd_parent_addr} >= alloc_q) begin
                        status_d = RSP_BADADDR;
                        state_d  = S_WR;
                     end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = cmd_parent_addr;
                        state_d   = S_RD;
                     end
                  end
                  OP_CLEAR: begin
                     status_d  = RSP_OK;
                     state_d   = S_CLR;
                     wr_en_d   = 1'b1;
                     wr_addr_d = '0;
                     wr_sel_d  = SEL_ALL;
                  end
                  default: begin
                     status_d = RSP_BADOP;
                     state_d  = S_WR;
                  end
               endcase
            end
         end
         S_RD: state_d = S_CMP;
         S_CMP: begin
            state_d = S_WR;
            // An equal key is a match in the search stage, so it never links.
            if (key_q == mem_rd_word) begin
               status_d = RSP_DUP;
            end else if (key_q < mem_rd_word) begin
               if (mem_rd_lp_valid) begin
                  status_d = RSP_OCCUPIED;
               end else begin
                  status_d           = RSP_OK;
                  wr_en_d            = 1'b1;
                  wr_addr_d          = parent_q;
                  wr_sel_d[SEL_LEFT] = 1'b1;
                  wr_ptr_d           = child_q;
                  wr_ptr_valid_d     = 1'b1;
               end
            end else begin
               if (mem_rd_rp_valid) begin
                  status_d = RSP_OCCUPIED;
               end else begin
                  status_d            = RSP_OK;
                  wr_en_d             = 1'b1;
                  wr_addr_d           = parent_q;
                  wr_sel_d[SEL_RIGHT] = 1'b1;
                  wr_ptr_d            = child_q;
                  wr_ptr_valid_d      = 1'b1;
               end
            end
         end
         S_WR: begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = status_q;
            rsp_addr_d   = raddr_q;
            if (op_q == OP_INSERT && status_q == RSP_OK) begin
               alloc_d = alloc_q + CW'(1);
            end
         end
         S_CLR: begin
            if (wr_addr_q == LastAddr) begin
               state_d      = S_RESP;
               alloc_d      = '0;
               rsp_valid_d  = 1'b1;
               rsp_status_d = status_q;
               rsp_addr_d   = '0;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = wr_addr_q + AW'(1);
               wr_sel_d  = SEL_ALL;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d      = S_IDLE;
               rsp_valid_d  = 1'b0;
               rsp_status_d = '0;
               rsp_addr_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op_q           <= OP_INSERT;
         key_q          <= '0;
         parent_q       <= '0;
         child_q        <= '0;
         status_q       <= RSP_OK;
         raddr_q        <= '0;
         alloc_q        <= '0;
         cmd_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         rsp_status_q   <= '0;
         rsp_addr_q     <= '0;
         rd_en_q        <= 1'b0;
         rd_addr_q      <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_sel_q       <= '0;
         wr_word_q      <= '0;
         wr_ptr_q       <= '0;
         wr_ptr_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         key_q          <= key_d;
         parent_q       <= parent_d;
         child_q        <= child_d;
         status_q       <= status_d;
         raddr_q        <= raddr_d;
         alloc_q        <= alloc_d;
         cmd_ready_q    <= cmd_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_status_q   <= rsp_status_d;
         rsp_addr_q     <= rsp_addr_d;
         rd_en_q        <= rd_en_d;
         rd_addr_q      <= rd_addr_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_sel_q       <= wr_sel_d;
         wr_word_q      <= wr_word_d;
         wr_ptr_q       <= wr_ptr_d;
         wr_ptr_valid_q <= wr_ptr_valid_d;
      end
   end

   assign cmd_ready        = cmd_ready_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_status       = rsp_status_q;
   assign rsp_addr         = rsp_addr_q;
   assign alloc_count      = alloc_q;
   assign mem_rd_en        = rd_en_q;
   assign mem_rd_addr      = rd_addr_q;
   assign mem_wr_en        = wr_en_q;
   assign mem_wr_addr      = wr_addr_q;
   assign mem_wr_sel       = wr_sel_q;
   assign mem_wr_word      = wr_word_q;
   assign mem_wr_ptr       = wr_ptr_q;
   assign mem_wr_ptr_valid = wr_ptr_valid_q;

endmodule
